// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: ALU select codes and sequencer state encoding shared by the
// multiply sequencer and the main control unit.
`default_nettype none
package mult_seq_pkg;

  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_OR   = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_ANDN = 3'd4;
  localparam logic [2:0] ALU_ORN  = 3'd5;
  localparam logic [2:0] ALU_SUB  = 3'd6;
  localparam logic [2:0] ALU_SLT  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage : mult_seq_pkg
`default_nettype wire

// File: rtl/mult_seq.sv
// mult_seq: unsigned WIDTHxWIDTH shift-add multiplier (multu) that borrows the
// shared ALU one step per granted cycle; product lands in hi/lo.
`default_nettype none
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  mult_state_t      state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] mcand;
  logic             carry;

  // ALU operands track the registers in RUN regardless of grant; the
  // datapath mux decides whether the sequencer actually owns the ALU.
  always_comb begin
    alu_sel = ALU_ADD;
    alu_a   = '0;
    alu_b   = '0;
    if (state == RUN) begin
      alu_a = hi;
      alu_b = lo[0] ? mcand : '0;
    end
  end

  // The ALU has no carry out; an unsigned wrap shows up as sum < addend.
  assign carry = (alu_out < hi);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      alu_req <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      count   <= '0;
      mcand   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand   <= op_a;
            hi      <= '0;
            lo      <= op_b;
            count   <= '0;
            busy    <= 1'b1;
            alu_req <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (alu_gnt) begin
            {hi, lo} <= {carry, alu_out, lo[WIDTH-1:1]};
            count    <= count + 1'b1;
            if (count == LAST_STEP) begin
              done    <= 1'b1;
              alu_req <= 1'b0;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          alu_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule : mult_seq
`default_nettype wire
